pkt_fifo_commit: RTL and testbench
==================================

PKT_FIFO_COMMIT -- requirements
Module: pkt_fifo_commit

Interface
REQ-001 SHALL have parameter DATA_WD, default 8, data word width.
REQ-002 SHALL have parameter PTR_WD, default 6, address width; DEPTH = 2^PTR_WD words.
REQ-003 SHALL have parameter AFULL_TH, default 48, almost-full threshold in words; legal range 1..DEPTH.
REQ-004 SHALL have ports: clk  in  1  clock, all logic on rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: wr_en  in  1  push strobe; wr_data  in  DATA_WD  push word; commit  in  1  accept pending packet; discard  in  1  drop pending packet.
REQ-006 SHALL have ports: wr_ready  out  1  space for one push; almost_full  out  1  occupancy >= AFULL_TH; ovf_err  out  1  one-cycle pulse on rejected push.
REQ-007 SHALL have ports: rd_valid  out  1  committed word available; rd_ready  in  1  consumer accepts; rd_data  out  DATA_WD  head word.
REQ-008 SHALL have ports: level  out  PTR_WD+1  committed unread words (0..DEPTH); free  out  PTR_WD+1  DEPTH minus total occupancy, pending words included.

Function
REQ-009 SHALL keep three PTR_WD+1-bit pointers (MSB = wrap bit): rd_ptr, commit_ptr, spec_ptr.
REQ-010 SHALL accept a push when wr_en && wr_ready && !discard: write at spec_ptr, then spec_ptr+1.
REQ-011 SHALL drive wr_ready = (spec_ptr - rd_ptr) != DEPTH, combinationally from registered pointers.
REQ-012 SHALL pulse ovf_err for one cycle, next cycle, when wr_en && !wr_ready; data dropped, pointers unchanged.
REQ-013 SHALL on commit (no discard) set commit_ptr to spec_ptr after this cycle's push; a push in the commit cycle is part of the committed packet.
REQ-014 SHALL on discard set spec_ptr to commit_ptr and ignore any same-cycle wr_en and commit (discard has priority).
REQ-015 SHALL treat commit or discard with no pending words as a no-op.
REQ-016 SHALL drive rd_valid = (commit_ptr != rd_ptr); pending words are never readable.
REQ-017 SHALL present rd_data = mem[rd_ptr] combinationally (fall-through, zero latency); rd_ptr+1 when rd_valid && rd_ready.
REQ-018 SHALL derive level = commit_ptr - rd_ptr and free = DEPTH - (spec_ptr - rd_ptr), modulo 2^(PTR_WD+1), from registered state, so they reflect the previous edge.
REQ-019 SHALL assert almost_full when (spec_ptr - rd_ptr) >= AFULL_TH.
REQ-020 SHALL support simultaneous push, pop and commit in one cycle with each applied independently.
REQ-021 SHALL wrap all pointers naturally at 2^(PTR_WD+1); full/empty distinguished by wrap bit.

Reset
REQ-022 SHALL on rst_n low clear all pointers and ovf_err: rd_valid=0, wr_ready=1, level=0, free=DEPTH, almost_full=0.
REQ-023 SHALL lose any pending and committed packet on reset mid-operation; memory contents not reset.

Configuration
REQ-024 SHALL with PKT_FIFO_STATS_EN defined add outputs drop_cnt out 16 and commit_cnt out 16: drop_cnt +1 per effective discard, commit_cnt +1 per effective commit, both saturating at 0xFFFF, cleared by reset.
REQ-025 SHALL without PKT_FIFO_STATS_EN omit both ports and counters, with otherwise identical behaviour.

Structure
REQ-026 SHALL place pointer-width helper constants and the stats counter width (16) in shared package yas_pkg.
REQ-027 SHALL instantiate storage as sub-module pkt_fifo_mem (1 write port, 1 asynchronous read port, DATA_WD x DEPTH, no reset).

Verification
REQ-028 Push 5 words A0..A4, commit with A4 -> level=5 next cycle; rd_valid=1, reads return A0..A4 in order, then rd_valid=0.
REQ-029 Push 3 words, discard -> level=0, free=64, rd_valid never asserted; next packet B0..B1 committed reads B0,B1.
REQ-030 Push 64 words without pop -> wr_ready=0, free=0; 65th wr_en -> ovf_err one cycle, word dropped; commit -> level=64.
REQ-031 Discard, commit and wr_en in same cycle with 2 pending words -> push ignored, spec_ptr = commit_ptr, level unchanged.
REQ-032 Stream 200 words in 10-word committed packets with rd_ready always 1 -> pointers wrap, data in order, no ovf_err, almost_full never set.
REQ-033 With PKT_FIFO_STATS_EN: 3 commits, 2 discards, 1 empty commit -> commit_cnt=3, drop_cnt=2; reset mid-packet -> both 0, rd_valid=0.

Source files
------------

// File: rtl/yas_pkg.sv
// Shared constants and helpers for the packet FIFO slice.
//   STAT_WD / STAT_MAX : width and saturation value of the statistics counters
//   ptr_depth()        : number of words addressed by a pointer of a given width
//   ptr_full_wd()      : pointer width including the wrap bit
package yas_pkg;

    localparam int unsigned STAT_WD = 16;
    localparam logic [STAT_WD-1:0] STAT_MAX = '1;

    function automatic int unsigned ptr_depth(input int unsigned ptr_wd);
        return 32'd1 << ptr_wd;
    endfunction

    function automatic int unsigned ptr_full_wd(input int unsigned ptr_wd);
        return ptr_wd + 32'd1;
    endfunction

endpackage

// File: rtl/pkt_fifo_commit_if.sv
// Producer/consumer bundle of the packet FIFO.
//   master : drives wr_en/wr_data/commit/discard/rd_ready, observes status and read data
//   slave  : the FIFO itself
// With PKT_FIFO_STATS_EN defined the bundle also carries drop_cnt/commit_cnt.
interface pkt_fifo_commit_if
    import yas_pkg::*;
#(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned PTR_WD  = 6
);
    localparam int unsigned PW = ptr_full_wd(PTR_WD);

    logic               wr_en;
    logic [DATA_WD-1:0] wr_data;
    logic               commit;
    logic               discard;
    logic               wr_ready;
    logic               almost_full;
    logic               ovf_err;
    logic               rd_valid;
    logic               rd_ready;
    logic [DATA_WD-1:0] rd_data;
    logic [PW-1:0]      level;
    logic [PW-1:0]      free;
`ifdef PKT_FIFO_STATS_EN
    logic [STAT_WD-1:0] drop_cnt;
    logic [STAT_WD-1:0] commit_cnt;
`endif

    modport master (
`ifdef PKT_FIFO_STATS_EN
        input  drop_cnt,
        input  commit_cnt,
`endif
        output wr_en,
        output wr_data,
        output commit,
        output discard,
        output rd_ready,
        input  wr_ready,
        input  almost_full,
        input  ovf_err,
        input  rd_valid,
        input  rd_data,
        input  level,
        input  free
    );

    modport slave (
`ifdef PKT_FIFO_STATS_EN
        output drop_cnt,
        output commit_cnt,
`endif
        input  wr_en,
        input  wr_data,
        input  commit,
        input  discard,
        input  rd_ready,
        output wr_ready,
        output almost_full,
        output ovf_err,
        output rd_valid,
        output rd_data,
        output level,
        output free
    );

endinterface

// File: rtl/pkt_fifo_mem.sv
// Packet FIFO storage: one synchronous write port, one asynchronous read port,
// DATA_WD x 2^PTR_WD words, contents not reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module pkt_fifo_mem
    import yas_pkg::*;
#(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned PTR_WD  = 6
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [PTR_WD-1:0]  i_waddr,
    input  logic [DATA_WD-1:0] i_wdata,
    input  logic [PTR_WD-1:0]  i_raddr,
    output logic [DATA_WD-1:0] o_rdata
);
    localparam int unsigned DEPTH = ptr_depth(PTR_WD);

    logic [DATA_WD-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Fall-through read port
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pkt_fifo_commit.sv
// Packet FIFO with commit/discard. Words are written speculatively behind
// spec_ptr; commit publishes them to the reader by moving commit_ptr up,
// discard rolls spec_ptr back. Only words between rd_ptr and commit_ptr are
// readable. Read is fall-through (rd_data valid with rd_valid, no latency).
// Optional statistics counters are enabled with the macro PKT_FIFO_STATS_EN.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pkt_fifo_commit_if.slave
//           in : wr_en, wr_data, commit, discard, rd_ready
//           out: wr_ready, almost_full, ovf_err, rd_valid, rd_data, level, free
//                (+ drop_cnt, commit_cnt with PKT_FIFO_STATS_EN)
module pkt_fifo_commit
    import yas_pkg::*;
#(
    parameter int unsigned DATA_WD  = 8,
    parameter int unsigned PTR_WD   = 6,
    parameter int unsigned AFULL_TH = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    pkt_fifo_commit_if.slave  bus
);
    localparam int unsigned PW    = ptr_full_wd(PTR_WD);
    localparam int unsigned DEPTH = ptr_depth(PTR_WD);
    localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_V = PW'(AFULL_TH);

    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_commit_ptr;
    logic [PW-1:0]      r_spec_ptr;
    logic               r_ovf_err;

    logic [PW-1:0]      w_occ;
    logic               w_wr_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_rd_valid;
    logic               w_commit_eff;
    logic               w_discard_eff;
    logic [PW-1:0]      w_spec_inc;
    logic [PW-1:0]      w_spec_nxt;
    logic [PW-1:0]      w_commit_nxt;
    logic [PW-1:0]      w_rd_nxt;
    logic [DATA_WD-1:0] w_rd_data;

    // Next-pointer logic; discard overrides both push and commit
    always_comb begin
        w_occ         = r_spec_ptr - r_rd_ptr;
        w_wr_ready    = (w_occ != DEPTH_V);
        w_push        = bus.wr_en && w_wr_ready && !bus.discard;
        w_spec_inc    = r_spec_ptr + PW'(w_push);
        // A push in the commit cycle belongs to the committed packet
        w_commit_eff  = bus.commit && !bus.discard && (w_spec_inc != r_commit_ptr);
        w_discard_eff = bus.discard && (r_spec_ptr != r_commit_ptr);
        w_spec_nxt    = bus.discard ? r_commit_ptr : w_spec_inc;
        w_commit_nxt  = w_commit_eff ? w_spec_inc : r_commit_ptr;
        w_rd_valid    = (r_commit_ptr != r_rd_ptr);
        w_pop         = w_rd_valid && bus.rd_ready;
        w_rd_nxt      = r_rd_ptr + PW'(w_pop);
    end

    // Pointer and error state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
            r_spec_ptr   <= '0;
            r_ovf_err    <= 1'b0;
        end else begin
            r_rd_ptr     <= w_rd_nxt;
            r_commit_ptr <= w_commit_nxt;
            r_spec_ptr   <= w_spec_nxt;
            r_ovf_err    <= bus.wr_en && !w_wr_ready;
        end
    end

    pkt_fifo_mem #(
        .DATA_WD (DATA_WD),
        .PTR_WD  (PTR_WD)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_spec_ptr[PTR_WD-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr[PTR_WD-1:0]),
        .o_rdata (w_rd_data)
    );

    // Status derived from registered pointers
    assign bus.wr_ready    = w_wr_ready;
    assign bus.rd_valid    = w_rd_valid;
    assign bus.rd_data     = w_rd_data;
    assign bus.level       = r_commit_ptr - r_rd_ptr;
    assign bus.free        = DEPTH_V - w_occ;
    assign bus.almost_full = (w_occ >= AFULL_V);
    assign bus.ovf_err     = r_ovf_err;

`ifdef PKT_FIFO_STATS_EN
    logic [STAT_WD-1:0] r_drop_cnt;
    logic [STAT_WD-1:0] r_commit_cnt;

    // Saturating packet statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt   <= '0;
            r_commit_cnt <= '0;
        end else begin
            if (w_discard_eff && (r_drop_cnt != STAT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + STAT_WD'(1);
            end
            if (w_commit_eff && (r_commit_cnt != STAT_MAX)) begin
                r_commit_cnt <= r_commit_cnt + STAT_WD'(1);
            end
        end
    end

    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.commit_cnt = r_commit_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_discard_eff;
`endif

endmodule

// File: tb/tb_pkt_fifo_commit.sv
// Self-checking bench for pkt_fifo_commit (DEPTH 64, AFULL_TH 48).
// A reference model keeps a pending queue and a committed scoreboard; read
// data is popped from the scoreboard and compared when the DUT hands a word out.
module tb_pkt_fifo_commit;
    import yas_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb[$];
    logic [7:0] pend[$];
    logic       m_ovf;
    int         m_commit_cnt;
    int         m_drop_cnt;

    always #5 clk = ~clk;

    pkt_fifo_commit_if #(.DATA_WD(8), .PTR_WD(6)) bus ();

    pkt_fifo_commit #(
        .DATA_WD  (8),
        .PTR_WD   (6),
        .AFULL_TH (48)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.commit  = 1'b0;
        bus.discard = 1'b0;
        bus.rd_ready = 1'b0;
    endtask

    task automatic clear_model();
        sb.delete();
        pend.delete();
        m_ovf        = 1'b0;
        m_commit_cnt = 0;
        m_drop_cnt   = 0;
    endtask

    // One clock: drive at a negedge, update model, compare at the next negedge
    task automatic step(input logic wr, input logic [7:0] d, input logic cm,
                        input logic ds, input logic rr);
        int         occ;
        logic       push;
        logic [7:0] exp_d;
        occ = sb.size() + pend.size();
        if (rr && sb.size() > 0) begin
            exp_d = sb.pop_front();
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d) begin
                n_err++;
                $display("FAIL rd_data: got valid=%b data=%h, expected valid=1 data=%h",
                         bus.rd_valid, bus.rd_data, exp_d);
            end
        end
        push  = wr && (occ != 64) && !ds;
        m_ovf = wr && (occ == 64);
        if (ds) begin
            if (pend.size() > 0) m_drop_cnt++;
            pend.delete();
        end else begin
            if (push) pend.push_back(d);
            if (cm && pend.size() > 0) begin
                m_commit_cnt++;
                while (pend.size() > 0) sb.push_back(pend.pop_front());
            end
        end
        bus.wr_en    = wr;
        bus.wr_data  = d;
        bus.commit   = cm;
        bus.discard  = ds;
        bus.rd_ready = rr;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        occ = sb.size() + pend.size();
        n_cmp++;
        if (bus.rd_valid !== (sb.size() != 0) || bus.level !== 7'(sb.size()) ||
            bus.free !== 7'(64 - occ) || bus.wr_ready !== (occ != 64) ||
            bus.almost_full !== (occ >= 48) || bus.ovf_err !== m_ovf) begin
            n_err++;
            $display("FAIL status: got v=%b lvl=%0d free=%0d rdy=%b af=%b ovf=%b, expected v=%b lvl=%0d free=%0d rdy=%b af=%b ovf=%b",
                     bus.rd_valid, bus.level, bus.free, bus.wr_ready, bus.almost_full, bus.ovf_err,
                     sb.size() != 0, sb.size(), 64 - occ, occ != 64, occ >= 48, m_ovf);
        end
`ifdef PKT_FIFO_STATS_EN
        n_cmp++;
        if (bus.commit_cnt !== 16'(m_commit_cnt) || bus.drop_cnt !== 16'(m_drop_cnt)) begin
            n_err++;
            $display("FAIL stats: got commit=%0d drop=%0d, expected commit=%0d drop=%0d",
                     bus.commit_cnt, bus.drop_cnt, m_commit_cnt, m_drop_cnt);
        end
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d words still expected after cycle budget", sb.size());
        end
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        clear_model();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1 || bus.level !== 7'd0 ||
            bus.free !== 7'd64 || bus.almost_full !== 1'b0 || bus.ovf_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got v=%b rdy=%b lvl=%0d free=%0d af=%b ovf=%b, expected 0 1 0 64 0 0",
                     bus.rd_valid, bus.wr_ready, bus.level, bus.free, bus.almost_full, bus.ovf_err);
        end
    endtask

    task automatic test_commit();
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL commit_pending_hidden: got rd_valid=%b, expected 0", bus.rd_valid);
        end
        step(1'b1, 8'hA4, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.level !== 7'd5 || bus.rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL commit_level: got level=%0d v=%b, expected 5 1", bus.level, bus.rd_valid);
        end
        drain();
        n_cmp++;
        if (bus.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL commit_empty: got rd_valid=%b, expected 0", bus.rd_valid);
        end
    endtask

    task automatic test_discard();
        for (int i = 0; i < 3; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (bus.level !== 7'd0 || bus.free !== 7'd64 || bus.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL discard: got level=%0d free=%0d v=%b, expected 0 64 0",
                     bus.level, bus.free, bus.rd_valid);
        end
        step(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hB1, 1'b1, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i) ^ 8'h5A, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.wr_ready !== 1'b0 || bus.free !== 7'd0 || bus.almost_full !== 1'b1) begin
            n_err++;
            $display("FAIL full: got rdy=%b free=%0d af=%b, expected 0 0 1",
                     bus.wr_ready, bus.free, bus.almost_full);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.ovf_err !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_pulse: got ovf_err=%b, expected 1", bus.ovf_err);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.ovf_err !== 1'b0 || bus.level !== 7'd64) begin
            n_err++;
            $display("FAIL full_commit: got ovf=%b level=%0d, expected 0 64", bus.ovf_err, bus.level);
        end
        drain();
    endtask

    task automatic test_priority();
        step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bus.level !== 7'd1 || bus.free !== 7'd63) begin
            n_err++;
            $display("FAIL discard_priority: got level=%0d free=%0d, expected 1 63", bus.level, bus.free);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.level !== 7'd1) begin
            n_err++;
            $display("FAIL empty_commit: got level=%0d, expected 1", bus.level);
        end
        drain();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 200; i++) step(1'b1, 8'(i * 3), (i % 10) == 9, 1'b0, 1'b1);
        drain();
    endtask

`ifdef PKT_FIFO_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            step(1'b1, 8'h10 + 8'(p), 1'b0, 1'b0, 1'b1);
            step(1'b1, 8'h20 + 8'(p), 1'b1, 1'b0, 1'b1);
        end
        for (int p = 0; p < 2; p++) begin
            step(1'b1, 8'h30 + 8'(p), 1'b0, 1'b0, 1'b1);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (bus.commit_cnt !== 16'd3 || bus.drop_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL stats_counts: got commit=%0d drop=%0d, expected 3 2",
                     bus.commit_cnt, bus.drop_cnt);
        end
        drain();
    endtask
`endif

    task automatic test_reset_mid();
        step(1'b1, 8'h71, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.level !== 7'd0 || bus.free !== 7'd64 || bus.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b lvl=%0d free=%0d rdy=%b, expected 0 0 64 1",
                     bus.rd_valid, bus.level, bus.free, bus.wr_ready);
        end
`ifdef PKT_FIFO_STATS_EN
        n_cmp++;
        if (bus.commit_cnt !== 16'd0 || bus.drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_stats: got commit=%0d drop=%0d, expected 0 0",
                     bus.commit_cnt, bus.drop_cnt);
        end
`endif
        @(negedge clk);
        clear_model();
        rst_n = 1'b1;
        step(1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        clear_inputs();
        clear_model();
        test_reset();
        test_commit();
        test_discard();
        test_full();
        test_priority();
        test_stream();
`ifdef PKT_FIFO_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
